// File: rtl/alu_op_sequencer_if.sv
// Command, result and ALU-drive signals shared by the sequencer and whoever
// owns the datapath control and the ALU instance.
interface alu_op_sequencer_if #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [2:0]         cmd_op;
  logic [WIDTH-1:0]   cmd_a;
  logic [WIDTH-1:0]   cmd_b;
  logic [SHAMT_W-1:0] cmd_shamt;

  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic [2:0]         alu_select;
  logic               alu_c_in;
  logic [WIDTH:0]     alu_y;

  logic               res_valid;
  logic [WIDTH-1:0]   res_data;
  logic               res_carry;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_shamt, alu_y,
    output cmd_ready, alu_a, alu_b, alu_select, alu_c_in,
           res_valid, res_data, res_carry
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_shamt, alu_y,
    input  cmd_ready, alu_a, alu_b, alu_select, alu_c_in,
           res_valid, res_data, res_carry
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences high-level ops onto a 3-bit-select ALU: single-cycle ops, iterated
// 1-bit shifts, and shift-add multiply; returns a registered result strobe.
module alu_op_sequencer #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  alu_op_sequencer_if.slave   bus
);
  localparam int CW_MUL = $clog2(WIDTH + 1);
  localparam int CNT_W  = (SHAMT_W > CW_MUL) ? SHAMT_W : CW_MUL;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                         OP_XOR = 3'd4, OP_SLL = 3'd5, OP_SRL = 3'd6, OP_MUL = 3'd7;

  typedef enum logic [2:0] {IDLE, EXEC, SHIFT, MUL_ADD, MUL_SHIFT, DONE} state_t;

  state_t           state;
  logic [2:0]       op;
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [CNT_W-1:0] count;
  logic [3:0]       opc;
  logic [WIDTH-1:0] drv_a, drv_b;
  logic [WIDTH-1:0] y_lo;
  logic             is_shift;

  assign bus.cmd_ready  = (state == IDLE) && !rst;
  assign bus.alu_select = opc[3:1];
  assign bus.alu_c_in   = opc[0];
  assign bus.alu_a      = drv_a;
  assign bus.alu_b      = drv_b;
  assign y_lo           = bus.alu_y[WIDTH-1:0];
  assign is_shift       = (bus.cmd_op == OP_SLL) || (bus.cmd_op == OP_SRL);

  // In EXEC, mcand/mplier simply hold operands A/B.
  always_comb begin
    opc   = 4'b1110;
    drv_a = '0;
    drv_b = '0;
    case (state)
      EXEC: begin
        drv_a = mcand;
        drv_b = mplier;
        case (op)
          OP_ADD:  opc = 4'b0010;
          OP_SUB:  opc = 4'b0101;
          OP_AND:  opc = 4'b1000;
          OP_OR:   opc = 4'b1001;
          OP_XOR:  opc = 4'b1010;
          default: opc = 4'b0000;
        endcase
      end
      SHIFT: begin
        drv_a = acc;
        opc   = (op == OP_SRL) ? 4'b1101 : 4'b1100;
      end
      MUL_ADD: begin
        drv_a = acc;
        drv_b = mcand;
        opc   = mplier[0] ? 4'b0010 : 4'b0000;
      end
      MUL_SHIFT: begin
        drv_a = mcand;
        opc   = 4'b1100;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      op            <= '0;
      acc           <= '0;
      mcand         <= '0;
      mplier        <= '0;
      count         <= '0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_carry <= 1'b0;
    end else begin
      bus.res_valid <= 1'b0;
      case (state)
        IDLE: if (bus.cmd_valid) begin
          op     <= bus.cmd_op;
          mcand  <= bus.cmd_a;
          mplier <= bus.cmd_b;
          acc    <= '0;
          count  <= '0;
          if (is_shift && bus.cmd_shamt != '0) begin
            acc   <= bus.cmd_a;
            count <= CNT_W'(bus.cmd_shamt);
            state <= SHIFT;
          end else if (bus.cmd_op == OP_MUL) begin
            state <= MUL_ADD;
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          bus.res_data  <= y_lo;
          bus.res_carry <= (op == OP_ADD || op == OP_SUB) ? bus.alu_y[WIDTH] : 1'b0;
          bus.res_valid <= 1'b1;
          state         <= DONE;
        end
        SHIFT: begin
          acc   <= y_lo;
          count <= count - 1'b1;
          if (count == CNT_W'(1)) begin
            bus.res_data  <= y_lo;
            bus.res_carry <= 1'b0;
            bus.res_valid <= 1'b1;
            state         <= DONE;
          end
        end
        MUL_ADD: begin
          acc   <= y_lo;
          state <= MUL_SHIFT;
        end
        MUL_SHIFT: begin
          mcand  <= y_lo;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          // acc is final here: the last MUL_ADD already happened.
          if (count == CNT_W'(WIDTH - 1)) begin
            bus.res_data  <= acc;
            bus.res_carry <= 1'b0;
            bus.res_valid <= 1'b1;
            state         <= DONE;
          end else begin
            state <= MUL_ADD;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural 3-bit-select ALU.
module tb_alu_op_sequencer;
  localparam int WIDTH = 8, SHAMT_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_op_sequencer_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus ();
  alu_op_sequencer #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Behavioural ALU: {select, c_in} opcode map
  always_comb begin
    case ({bus.alu_select, bus.alu_c_in})
      4'b0000: bus.alu_y = {1'b0, bus.alu_a};
      4'b0010: bus.alu_y = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      4'b0101: bus.alu_y = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 9'd1;
      4'b1000: bus.alu_y = {1'b0, bus.alu_a & bus.alu_b};
      4'b1001: bus.alu_y = {1'b0, bus.alu_a | bus.alu_b};
      4'b1010: bus.alu_y = {1'b0, bus.alu_a ^ bus.alu_b};
      4'b1100: bus.alu_y = {bus.alu_a[WIDTH-1], bus.alu_a << 1};
      4'b1101: bus.alu_y = {1'b0, bus.alu_a >> 1};
      default: bus.alu_y = '0;
    endcase
  end

  typedef struct {
    string            name;
    logic [WIDTH-1:0] data;
    logic             carry;
    int               lat;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t model(input string nm, input logic [2:0] op,
                                 input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [SHAMT_W-1:0] sh);
    exp_t e;
    logic [2*WIDTH-1:0] p;
    e.name = nm; e.carry = 1'b0; e.lat = 2; e.data = '0;
    case (op)
      3'd0: {e.carry, e.data} = {1'b0, a} + {1'b0, b};
      3'd1: begin e.data = a - b; e.carry = (a >= b); end
      3'd2: e.data = a & b;
      3'd3: e.data = a | b;
      3'd4: e.data = a ^ b;
      3'd5: begin e.data = a << sh; e.lat = (sh == 0) ? 2 : int'(sh) + 1; end
      3'd6: begin e.data = a >> sh; e.lat = (sh == 0) ? 2 : int'(sh) + 1; end
      default: begin
        p = (2*WIDTH)'(a) * (2*WIDTH)'(b);
        e.data = p[WIDTH-1:0];
        e.lat = 2 * WIDTH + 1;
      end
    endcase
    return e;
  endfunction

  // Drives one command, pushes its expectation, and collects the DUT result.
  task automatic run(input string nm, input logic [2:0] op, input logic [WIDTH-1:0] a,
                     input logic [WIDTH-1:0] b, input logic [SHAMT_W-1:0] sh,
                     output logic got, output logic [WIDTH-1:0] d, output logic c,
                     output int lat, output int shift_cycles, output logic [3:0] first_opc);
    int k;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_shamt = sh;
    k = cyc + 1;
    sb.push_back(model(nm, op, a, b, sh));
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    got = 1'b0; lat = -1; d = '0; c = 1'b0; shift_cycles = 0; first_opc = 4'hF;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (i == 0) first_opc = {bus.alu_select, bus.alu_c_in};
      if ({bus.alu_select, bus.alu_c_in} == 4'b1100 || {bus.alu_select, bus.alu_c_in} == 4'b1101)
        shift_cycles++;
      if (bus.res_valid) begin
        got = 1'b1; lat = cyc + 1 - k; d = bus.res_data; c = bus.res_carry;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", bus.cmd_ready); end
    n_checks++; if (bus.res_valid !== 1'b0 || bus.res_data !== '0 || bus.res_carry !== 1'b0) begin
      n_fail++; $display("FAIL reset_res got v=%b d=%h c=%b exp 0/00/0", bus.res_valid, bus.res_data, bus.res_carry); end
    n_checks++; if ({bus.alu_select, bus.alu_c_in} !== 4'b1110 || bus.alu_a !== '0 || bus.alu_b !== '0) begin
      n_fail++; $display("FAIL reset_alu got opc=%b a=%h b=%h exp 1110/00/00", {bus.alu_select, bus.alu_c_in}, bus.alu_a, bus.alu_b); end
    rst = 1'b0;
    #1;
    n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got=%b exp=1", bus.cmd_ready); end
  endtask

  task automatic test_add();
    logic got, c; logic [WIDTH-1:0] d; int lat, sc; logic [3:0] fo; exp_t e;
    run("add_f0_20", 3'd0, 8'hF0, 8'h20, 3'd0, got, d, c, lat, sc, fo);
    e = sb.pop_front();
    n_checks++; if (fo !== 4'b0010) begin n_fail++; $display("FAIL add_opcode got=%b exp=0010", fo); end
    n_checks++; if (!got || d !== e.data || c !== e.carry) begin
      n_fail++; $display("FAIL %s got=%h/%b exp=%h/%b", e.name, d, c, e.data, e.carry); end
    n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL %s_latency got=%0d exp=%0d", e.name, lat, e.lat); end
    @(negedge clk);
    n_checks++; if (bus.res_valid !== 1'b0 || bus.res_data !== e.data) begin
      n_fail++; $display("FAIL add_pulse_hold got v=%b d=%h exp v=0 d=%h", bus.res_valid, bus.res_data, e.data); end
  endtask

  task automatic test_alu_ops();
    logic [2:0]       top[5] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
    logic [WIDTH-1:0] ta[5]  = '{8'h07, 8'h05, 8'hCA, 8'hCA, 8'hCA};
    logic [WIDTH-1:0] tb[5]  = '{8'h05, 8'h07, 8'h5F, 8'h5F, 8'h5F};
    logic got, c; logic [WIDTH-1:0] d; int lat, sc; logic [3:0] fo; exp_t e;
    for (int i = 0; i < 5; i++) begin
      run($sformatf("op%0d_%h_%h", top[i], ta[i], tb[i]), top[i], ta[i], tb[i], 3'd0, got, d, c, lat, sc, fo);
      e = sb.pop_front();
      n_checks++; if (!got || d !== e.data || c !== e.carry || lat !== e.lat) begin
        n_fail++; $display("FAIL %s got=%h/%b lat=%0d exp=%h/%b lat=%0d", e.name, d, c, lat, e.data, e.carry, e.lat); end
    end
  endtask

  task automatic test_shift();
    logic [2:0]         top[4] = '{3'd5, 3'd6, 3'd5, 3'd6};
    logic [SHAMT_W-1:0] tsh[4] = '{3'd3, 3'd3, 3'd0, 3'd7};
    int                 tsc[4] = '{3, 3, 0, 7};
    logic got, c; logic [WIDTH-1:0] d; int lat, sc; logic [3:0] fo; exp_t e;
    for (int i = 0; i < 4; i++) begin
      run($sformatf("shift%0d_sh%0d", top[i], tsh[i]), top[i], 8'h81, 8'hFF, tsh[i], got, d, c, lat, sc, fo);
      e = sb.pop_front();
      n_checks++; if (!got || d !== e.data || c !== e.carry || lat !== e.lat) begin
        n_fail++; $display("FAIL %s got=%h/%b lat=%0d exp=%h/%b lat=%0d", e.name, d, c, lat, e.data, e.carry, e.lat); end
      n_checks++; if (sc !== tsc[i]) begin n_fail++; $display("FAIL %s_shift_cycles got=%0d exp=%0d", e.name, sc, tsc[i]); end
    end
  endtask

  task automatic test_mul();
    logic [WIDTH-1:0] ta[4] = '{8'd13, 8'hFF, 8'h5A, 8'h80};
    logic [WIDTH-1:0] tb[4] = '{8'd11, 8'hFF, 8'h00, 8'h03};
    logic got, c; logic [WIDTH-1:0] d; int lat, sc; logic [3:0] fo; exp_t e;
    for (int i = 0; i < 4; i++) begin
      run($sformatf("mul_%h_%h", ta[i], tb[i]), 3'd7, ta[i], tb[i], 3'd0, got, d, c, lat, sc, fo);
      e = sb.pop_front();
      n_checks++; if (!got || d !== e.data || c !== e.carry || lat !== e.lat) begin
        n_fail++; $display("FAIL %s got=%h/%b lat=%0d exp=%h/%b lat=%0d", e.name, d, c, lat, e.data, e.carry, e.lat); end
    end
  endtask

  task automatic test_back_to_back();
    int k, ready_seen, extra, lat; logic got; logic [WIDTH-1:0] d; exp_t e;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd7; bus.cmd_a = 8'd13; bus.cmd_b = 8'd11; bus.cmd_shamt = 3'd0;
    k = cyc + 1;
    sb.push_back(model("busy_mul", 3'd7, 8'd13, 8'd11, 3'd0));
    @(posedge clk);
    #1 bus.cmd_op = 3'd0; bus.cmd_a = 8'h01; bus.cmd_b = 8'h01;
    ready_seen = 0; got = 1'b0; lat = -1; d = '0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) ready_seen++;
      if (bus.res_valid) begin got = 1'b1; lat = cyc + 1 - k; d = bus.res_data; end
    end
    bus.cmd_valid = 1'b0;
    e = sb.pop_front();
    n_checks++; if (ready_seen !== 0) begin n_fail++; $display("FAIL busy_ready got=%0d cycles exp=0", ready_seen); end
    n_checks++; if (!got || d !== e.data || lat !== e.lat) begin
      n_fail++; $display("FAIL %s got=%h lat=%0d exp=%h lat=%0d", e.name, d, lat, e.data, e.lat); end
    extra = 0;
    repeat (6) begin @(negedge clk); if (bus.res_valid) extra++; end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL busy_no_second got=%0d pulses exp=0", extra); end
  endtask

  task automatic test_reset_mid_mul();
    int pulses, lat, sc; logic got, c; logic [WIDTH-1:0] d; logic [3:0] fo; exp_t e;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd7; bus.cmd_a = 8'hFF; bus.cmd_b = 8'hFF; bus.cmd_shamt = 3'd0;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.res_valid !== 1'b0 || bus.res_data !== '0 || bus.cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL midrst_state got v=%b d=%h rdy=%b exp 0/00/0", bus.res_valid, bus.res_data, bus.cmd_ready); end
    n_checks++; if ({bus.alu_select, bus.alu_c_in} !== 4'b1110) begin
      n_fail++; $display("FAIL midrst_opcode got=%b exp=1110", {bus.alu_select, bus.alu_c_in}); end
    rst = 1'b0;
    #1;
    n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got=%b exp=1", bus.cmd_ready); end
    pulses = 0;
    repeat (20) begin @(negedge clk); if (bus.res_valid) pulses++; end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL midrst_no_pulse got=%0d exp=0", pulses); end
    run("post_rst_add", 3'd0, 8'h01, 8'h01, 3'd0, got, d, c, lat, sc, fo);
    e = sb.pop_front();
    n_checks++; if (!got || d !== e.data || c !== e.carry || lat !== e.lat) begin
      n_fail++; $display("FAIL %s got=%h/%b lat=%0d exp=%h/%b lat=%0d", e.name, d, c, lat, e.data, e.carry, e.lat); end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_shamt = '0;
    test_reset();
    test_add();
    test_alu_ops();
    test_shift();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
